bus_mem_slave: RTL
==================

BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits (multiple of 8, at least 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of words in storage (power of 2).
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning extra cycles inserted before ack (0..15).
REQ-005 SHALL have parameter CNT_WIDTH, default 16, meaning width of the access counters.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port mem_req, input, 1, meaning request valid.
REQ-009 SHALL have port mem_we, input, 1, meaning 1 = write, 0 = read.
REQ-010 SHALL have port mem_addr, input, ADDR_WIDTH, meaning byte address.
REQ-011 SHALL have port mem_wdata, input, DATA_WIDTH, meaning write data.
REQ-012 SHALL have port mem_be, input, DATA_WIDTH/8, meaning write byte enables.
REQ-013 SHALL have port mem_rdata, output, DATA_WIDTH, meaning read data, valid while mem_ack=1.
REQ-014 SHALL have port mem_ack, output, 1, meaning one-cycle completion pulse.
REQ-015 SHALL have port mem_err, output, 1, meaning error status, qualified by mem_ack.
REQ-016 SHALL have port busy, output, 1, meaning transaction in flight (state not IDLE).
REQ-017 SHALL have ports rd_cnt and wr_cnt, output, CNT_WIDTH each, meaning completed good reads and good writes.

Function
REQ-018 SHALL implement three states: IDLE, WAIT, RESP.
REQ-019 In IDLE with mem_req=1, SHALL capture mem_we, mem_addr, mem_wdata and mem_be.
- Next state after capture is RESP if WAIT_STATES=0, else WAIT with the wait counter loaded to WAIT_STATES.
REQ-020 WAIT SHALL decrement the counter each cycle and enter RESP on the cycle after the counter reaches 1.
REQ-021 mem_ack SHALL be 1 exactly during the single RESP cycle; RESP SHALL always return to IDLE.
- Latency: mem_req sampled high in IDLE cycle T gives mem_ack in cycle T+1+WAIT_STATES.
REQ-022 mem_req SHALL be ignored outside IDLE.
- Changes to mem_req, mem_addr or mem_wdata during WAIT or RESP do not affect the captured transaction.
- mem_req high in an IDLE cycle is always a new request; the master drops mem_req the cycle after mem_ack.
REQ-023 Word index SHALL be mem_addr[log2(DEPTH)+OFF-1:OFF], where OFF = log2(DATA_WIDTH/8).
REQ-024 A request SHALL be in error if mem_addr is misaligned (low OFF bits nonzero) or if mem_addr >= DEPTH*(DATA_WIDTH/8).
- Error response: mem_ack=1 with mem_err=1, mem_rdata=0, no storage update, no counter increment.
REQ-025 A good write SHALL update only the bytes whose mem_be bit is 1.
- The update commits on the clock edge entering RESP.
- mem_be=0 still acks and still increments wr_cnt.
REQ-026 A good read SHALL return the full word in mem_rdata during RESP, ignoring mem_be.
REQ-027 mem_rdata and mem_err SHALL be 0 whenever mem_ack=0.
REQ-028 rd_cnt/wr_cnt SHALL increment on the edge entering RESP for good accesses and wrap from all-ones to 0.
REQ-029 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.

Reset
REQ-030 On rst=1 at a clock edge, state SHALL go to IDLE.
- mem_ack, mem_err, mem_rdata, busy, rd_cnt and wr_cnt go to 0.
- Reset takes priority over all other activity.
REQ-031 Reset asserted mid-transaction in WAIT SHALL abort it: no ack, no storage write, no counter change.
REQ-032 Storage contents SHALL NOT be cleared by reset; they are undefined until written.

Verification (DATA_WIDTH=32, DEPTH=256, WAIT_STATES=2 unless noted)
REQ-033 Write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10.
- Each access: ack 3 cycles after req.
- Read returns 0xDEADBEEF, err=0.
- Final counts: wr_cnt=1, rd_cnt=1.
REQ-034 Write 0x11223344 to 0x20 with be=0xF, then write 0xAABBCCDD to 0x20 with be=0x5, then read 0x20.
- Read returns 0x11BB33DD.
REQ-035 Read at 0x400 (out of range), then read at 0x13 (misaligned).
- Both give ack with err=1 and rdata=0.
- Counters unchanged.
REQ-036 Assert rst in the first WAIT cycle of a write of 0x55 to 0x08.
- No ack is produced and busy goes to 0.
- A following read of 0x08 returns the prior contents.
REQ-037 WAIT_STATES=0: back-to-back reads of 0x0 and 0x4.
- Each ack arrives in the cycle after req is sampled.
- busy=1 only in the RESP cycle.
REQ-038 CNT_WIDTH=2: five good writes.
- wr_cnt sequence is 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/bus_mem_slave.sv
// Word-addressed memory slave with a simple req/ack handshake, programmable wait states,
// byte-enable writes, address error detection and wrapping good-access counters.
`timescale 1ns/1ps
module bus_mem_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_ack,
  output logic                    mem_err,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    rd_cnt,
  output logic [CNT_WIDTH-1:0]    wr_cnt
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned OFF    = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TOP_SH = $clog2(DEPTH) + OFF;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           be_q, be_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // With zero wait states the commit happens on the capture edge, so the live inputs are used.
  logic                    in_idle, commit;
  logic                    cur_we, cur_err;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic [NB-1:0]           cur_be;
  logic [IDX_W-1:0]        cur_idx;

  always_comb begin
    in_idle   = (state_q == StIdle);
    cur_we    = in_idle ? mem_we    : we_q;
    cur_addr  = in_idle ? mem_addr  : addr_q;
    cur_wdata = in_idle ? mem_wdata : wdata_q;
    cur_be    = in_idle ? mem_be    : be_q;
    cur_idx   = IDX_W'(cur_addr >> OFF);
    cur_err   = ((cur_addr & ADDR_WIDTH'(NB - 1)) != '0) || ((cur_addr >> TOP_SH) != '0);
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    commit   = 1'b0;

    case (state_q)
      StIdle: begin
        if (mem_req) begin
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          be_d    = mem_be;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            wcnt_d  = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        if (wcnt_q <= 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
        wcnt_d = wcnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (commit) begin
      ack_d = 1'b1;
      err_d = cur_err;
      if (!cur_err) begin
        if (cur_we) begin
          wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
          rdata_d  = mem_q[cur_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wcnt_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage is deliberately not reset; an edge with rst high never writes.
  always_ff @(posedge clk) begin
    if (!rst && commit && cur_we && !cur_err) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (cur_be[b]) mem_q[cur_idx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
      end
    end
  end

  assign mem_ack   = ack_q;
  assign mem_err   = err_q;
  assign mem_rdata = rdata_q;
  assign busy      = (state_q != StIdle);
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule
